// File: rtl/uart_pkg.sv
// ============================================================================
//  Module  : uart_pkg
//  Brief   : Shared types and helpers for the UART transmit controller.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Transmit frame sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // frame_pos is four bits wide; the longest legal frame is 1+8+1+2 = 12.
  localparam int unsigned POS_W = 4;

  // Widest data field the parity helper has to cover.
  localparam int unsigned MAX_DATA_BITS = 8;

  // Number of bit periods in one frame: start + data + parity + stop(s).
  function automatic int unsigned frame_len(input int unsigned data_bits,
                                            input int unsigned parity_en,
                                            input int unsigned stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

  // Longest frame any legal parameter set can produce.
  localparam int unsigned FRAME_LEN_MAX = frame_len(8, 1, 2);

  // Parity of a zero-extended data word. Zero padding does not change the
  // XOR reduction, so narrower data fields can share this helper.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_ctrl_if.sv
// ============================================================================
//  Module  : uart_tx_ctrl_if
//  Brief   : Host byte handshake plus serial/status outputs of the UART TX
//            controller. The host is the master, the controller the slave.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_tx_ctrl_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_serial;
  logic [3:0]           frame_pos;
  logic                 tx_busy;
  logic                 tx_done;

  // Host side: offers bytes and observes line/status.
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_serial,
    input  frame_pos,
    input  tx_busy,
    input  tx_done
  );

  // Controller side.
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_serial,
    output frame_pos,
    output tx_busy,
    output tx_done
  );

endinterface

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
//  Module  : uart_baud_gen
//  Brief   : Bit-period divider. Counts 0..BAUD_DIV-1 while not cleared and
//            pulses o_tick on the last count of every bit period.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module uart_baud_gen #(
  parameter int BAUD_DIV = 434
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_clear,
  output logic      o_tick
);

  localparam int              CNT_W  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] r_count;

  // Clear dominates so the first bit after leaving IDLE starts at count 0.
  assign o_tick = ~i_clear && (r_count == C_LAST);

  // Divider counter: held at zero while cleared, wraps to zero on tick.
  always_ff @(posedge clk) begin
    if (reset || i_clear || o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
// ============================================================================
//  Module  : uart_tx_ctrl
//  Brief   : UART transmit frame sequencer. Accepts one byte per valid/ready
//            handshake and serialises start, data (LSB first), optional
//            parity and stop bits onto an idle-high line.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  wire logic     clk,
  input  wire logic     reset,
  uart_tx_ctrl_if.slave bus
);

  localparam int unsigned     FRAME_LEN       = frame_len(DATA_BITS, PARITY_EN, STOP_BITS);
  localparam logic [POS_W-1:0] C_LAST_DATA_POS = POS_W'(DATA_BITS + 1);
  localparam logic [POS_W-1:0] C_LAST_POS      = POS_W'(FRAME_LEN);
  localparam logic             C_ODD           = (PARITY_ODD != 0);
  localparam logic             C_HAS_PARITY    = (PARITY_EN != 0);

  tx_state_e            r_state;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_parity;
  logic                 r_serial;
  logic [POS_W-1:0]     r_pos;
  logic                 r_done;

  tx_state_e            w_state_nxt;
  logic [DATA_BITS-1:0] w_shreg_nxt;
  logic                 w_parity_nxt;
  logic                 w_serial_nxt;
  logic [POS_W-1:0]     w_pos_nxt;
  logic                 w_done_nxt;

  logic                 w_idle;
  logic                 w_tick;
  logic                 w_ready;
  logic                 w_accept;

  assign w_idle   = (r_state == IDLE);
  assign w_ready  = w_idle && !reset;
  assign w_accept = bus.tx_valid && w_ready;

  // One divider for the whole frame; holding it clear in IDLE aligns every
  // frame's first bit to a fresh count, so there is no inter-frame phase slip.
  uart_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_gen (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_idle),
    .o_tick  (w_tick)
  );

  // Next-state and next-output logic; all bit transitions happen on a tick.
  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_parity_nxt = r_parity;
    w_serial_nxt = r_serial;
    w_pos_nxt    = r_pos;
    w_done_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        w_serial_nxt = 1'b1;
        w_pos_nxt    = '0;
        if (w_accept) begin
          w_state_nxt  = START;
          w_shreg_nxt  = bus.tx_data;
          w_parity_nxt = parity_bit(MAX_DATA_BITS'(bus.tx_data), C_ODD);
          w_serial_nxt = 1'b0;
          w_pos_nxt    = POS_W'(1);
        end
      end

      START: begin
        if (w_tick) begin
          w_state_nxt  = DATA;
          w_serial_nxt = r_shreg[0];
          w_shreg_nxt  = r_shreg >> 1;
          w_pos_nxt    = r_pos + 1'b1;
        end
      end

      DATA: begin
        if (w_tick) begin
          w_pos_nxt = r_pos + 1'b1;
          if (r_pos == C_LAST_DATA_POS) begin
            if (C_HAS_PARITY) begin
              w_state_nxt  = PARITY;
              w_serial_nxt = r_parity;
            end else begin
              w_state_nxt  = STOP;
              w_serial_nxt = 1'b1;
            end
          end else begin
            w_serial_nxt = r_shreg[0];
            w_shreg_nxt  = r_shreg >> 1;
          end
        end
      end

      PARITY: begin
        if (w_tick) begin
          w_state_nxt  = STOP;
          w_serial_nxt = 1'b1;
          w_pos_nxt    = r_pos + 1'b1;
        end
      end

      STOP: begin
        w_serial_nxt = 1'b1;
        if (w_tick) begin
          // frame_pos tells the stop bits apart, so two stop bits need no
          // extra state.
          if (r_pos == C_LAST_POS) begin
            w_state_nxt = IDLE;
            w_pos_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_pos_nxt = r_pos + 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt  = IDLE;
        w_serial_nxt = 1'b1;
        w_pos_nxt    = '0;
      end
    endcase
  end

  // State and datapath registers; reset returns the line high immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_parity <= 1'b0;
      r_serial <= 1'b1;
      r_pos    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_parity <= w_parity_nxt;
      r_serial <= w_serial_nxt;
      r_pos    <= w_pos_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.tx_ready  = w_ready;
  assign bus.tx_serial = r_serial;
  assign bus.frame_pos = r_pos;
  assign bus.tx_busy   = !w_idle;
  assign bus.tx_done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
// ============================================================================
//  Module  : tb_uart_tx_ctrl
//  Brief   : Self-checking bench for uart_tx_ctrl with three parameter sets
//            sharing one clock and reset.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_ctrl;

  localparam int BAUD = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_BITS(8)) if0 ();
  uart_tx_ctrl_if #(.DATA_BITS(8)) if1 ();
  uart_tx_ctrl_if #(.DATA_BITS(5)) if2 ();

  // Defaults: 8 data bits, even parity, 1 stop.
  uart_tx_ctrl #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  // Odd parity, 2 stop bits.
  uart_tx_ctrl #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
    u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  // 5 data bits, no parity, 1 stop.
  uart_tx_ctrl #(.BAUD_DIV(BAUD), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

  int sel = 0;
  logic       m_serial, m_ready, m_busy, m_done;
  logic [3:0] m_pos;

  // Route the selected instance's outputs to the monitor signals.
  always_comb begin
    m_serial = if0.tx_serial;
    m_ready  = if0.tx_ready;
    m_busy   = if0.tx_busy;
    m_done   = if0.tx_done;
    m_pos    = if0.frame_pos;
    case (sel)
      1: begin
        m_serial = if1.tx_serial; m_ready = if1.tx_ready; m_busy = if1.tx_busy;
        m_done   = if1.tx_done;   m_pos   = if1.frame_pos;
      end
      2: begin
        m_serial = if2.tx_serial; m_ready = if2.tx_ready; m_busy = if2.tx_busy;
        m_done   = if2.tx_done;   m_pos   = if2.frame_pos;
      end
      default: ;
    endcase
  end

  typedef struct packed {
    logic       ser;
    logic [3:0] pos;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Queue one bit period (BAUD cycles) of expected line value and position.
  function automatic void push_bit(input logic b, input int pos);
    exp_t e;
    e.ser = b;
    e.pos = 4'(pos);
    for (int c = 0; c < BAUD; c++) exp_q.push_back(e);
  endfunction

  // Reference frame: start, LSB-first data, optional parity, stop bits.
  function automatic void push_frame(input logic [7:0] d, input int db, input int pe,
                                     input int odd, input int sb);
    logic p;
    int   pos;
    p   = (odd != 0);
    pos = 1;
    push_bit(1'b0, pos);
    pos++;
    for (int i = 0; i < db; i++) begin
      push_bit(d[i], pos);
      p = p ^ d[i];
      pos++;
    end
    if (pe != 0) begin
      push_bit(p, pos);
      pos++;
    end
    for (int s = 0; s < sb; s++) begin
      push_bit(1'b1, pos);
      pos++;
    end
  endfunction

  task automatic drive(input logic v, input logic [7:0] d);
    case (sel)
      1:       begin if1.tx_valid = v; if1.tx_data = d;      end
      2:       begin if2.tx_valid = v; if2.tx_data = d[4:0]; end
      default: begin if0.tx_valid = v; if0.tx_data = d;      end
    endcase
  endtask

  // Offer a byte once ready; returns at the negedge of the first START cycle.
  task automatic send(input logic [7:0] d, input logic hold);
    int w;
    w = 0;
    while (m_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (m_ready !== 1'b1) begin
      checks++;
      $display("FAIL send_ready: tx_ready=%b after %0d cycles, required 1", m_ready, w);
    end
    drive(1'b1, d);
    @(negedge clk);
    if (!hold) drive(1'b0, d);
  endtask

  // Pop one expected cycle per clock and compare; then check the done cycle.
  task automatic check_frame(input string name, input logic hold, input logic disturb);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (m_serial !== e.ser || m_pos !== e.pos || m_busy !== 1'b1 || m_done !== 1'b0 ||
          (disturb && m_ready !== 1'b0))
        $display("FAIL %s cycle %0d: serial=%b pos=%0d busy=%b done=%b ready=%b, required serial=%b pos=%0d busy=1 done=0",
                 name, cyc, m_serial, m_pos, m_busy, m_done, m_ready, e.ser, e.pos);
      else
        passed++;
      if (disturb) begin
        if (exp_q.size() > 0) drive(cyc[0], 8'hFF);
        else                  drive(1'b0, 8'hFF);
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (m_done !== 1'b1 || m_pos !== 4'd0 || m_busy !== 1'b0 || m_ready !== 1'b1 || m_serial !== 1'b1)
      $display("FAIL %s_end after %0d cycles: done=%b pos=%0d busy=%b ready=%b serial=%b, required 1/0/0/1/1",
               name, cyc, m_done, m_pos, m_busy, m_ready, m_serial);
    else
      passed++;
    if (!hold) begin
      @(negedge clk);
      checks++;
      if (m_done !== 1'b0 || m_serial !== 1'b1 || m_busy !== 1'b0)
        $display("FAIL %s_pulse: done=%b serial=%b busy=%b, required 0/1/0", name, m_done, m_serial, m_busy);
      else
        passed++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if (m_serial !== 1'b1 || m_pos !== 4'd0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_ready !== 1'b0)
        $display("FAIL reset_state dut%0d: serial=%b pos=%0d busy=%b done=%b ready=%b, required 1/0/0/0/0",
                 s, m_serial, m_pos, m_busy, m_done, m_ready);
      else
        passed++;
    end
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if (m_ready !== 1'b1)
        $display("FAIL reset_release dut%0d: ready=%b, required 1", s, m_ready);
      else
        passed++;
    end
    sel = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    sel = 0;
    @(negedge clk);
    push_frame(8'h55, 8, 1, 0, 1);
    send(8'h55, 1'b0);
    check_frame("basic_55", 1'b0, 1'b0);
  endtask

  task automatic test_parity_stop2();
    sel = 1;
    @(negedge clk);
    push_frame(8'h03, 8, 1, 1, 2);
    send(8'h03, 1'b0);
    check_frame("odd_stop2_03", 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    sel = 0;
    @(negedge clk);
    push_frame(8'hA5, 8, 1, 0, 1);
    send(8'hA5, 1'b1);
    drive(1'b1, 8'h0F);
    check_frame("b2b_A5", 1'b1, 1'b0);
    push_frame(8'h0F, 8, 1, 0, 1);
    @(negedge clk);
    drive(1'b0, 8'h0F);
    check_frame("b2b_0F", 1'b0, 1'b0);
  endtask

  task automatic test_ignore_midframe();
    sel = 0;
    @(negedge clk);
    push_frame(8'h3C, 8, 1, 0, 1);
    send(8'h3C, 1'b0);
    check_frame("midframe_3C", 1'b0, 1'b1);
  endtask

  task automatic test_mid_reset();
    int  w;
    logic bad;
    sel = 0;
    @(negedge clk);
    send(8'h81, 1'b0);
    w = 0;
    while (m_pos !== 4'd5 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (m_pos !== 4'd5) $display("FAIL midreset_reach: pos=%0d, required 5", m_pos);
    else                passed++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (m_serial !== 1'b1 || m_pos !== 4'd0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_ready !== 1'b0)
      $display("FAIL midreset_state: serial=%b pos=%0d busy=%b done=%b ready=%b, required 1/0/0/0/0",
               m_serial, m_pos, m_busy, m_done, m_ready);
    else
      passed++;
    reset = 1'b0;
    #1;
    checks++;
    if (m_ready !== 1'b1) $display("FAIL midreset_ready: ready=%b, required 1", m_ready);
    else                  passed++;
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (m_done !== 1'b0 || m_serial !== 1'b1 || m_busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL midreset_quiet: done/serial/busy activity seen after reset, required none");
    else     passed++;
  endtask

  task automatic test_short_frame();
    sel = 2;
    @(negedge clk);
    push_frame(8'h1F, 5, 0, 0, 1);
    send(8'h1F, 1'b0);
    check_frame("short_1F", 1'b0, 1'b0);
  endtask

  initial begin
    if0.tx_valid = 1'b0; if0.tx_data = '0;
    if1.tx_valid = 1'b0; if1.tx_data = '0;
    if2.tx_valid = 1'b0; if2.tx_data = '0;
    test_reset();
    test_basic();
    test_parity_stop2();
    test_back_to_back();
    test_ignore_midframe();
    test_mid_reset();
    test_short_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
